// File: rtl/seg_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl_if
// Purpose : write/handshake bus and segment pins between the LSU
//           output-register decode (master) and seg_display_ctrl (slave).
// Signals :
//   i_wr_en      write strobe, sampled by the controller only in IDLE
//   i_wr_data    32-bit value to display
//   i_mode       0 = hexadecimal, 1 = unsigned decimal
//   o_busy       controller is converting/updating; writes are dropped
//   o_done       one-cycle pulse, new digits visible in the same cycle
//   o_io_hex0..7 active-low segments {g,f,e,d,c,b,a}, hex0 = least significant
// ---------------------------------------------------------------------------
interface seg_display_ctrl_if;
    logic        i_wr_en;
    logic [31:0] i_wr_data;
    logic        i_mode;
    logic        o_busy;
    logic        o_done;
    logic [6:0]  o_io_hex0;
    logic [6:0]  o_io_hex1;
    logic [6:0]  o_io_hex2;
    logic [6:0]  o_io_hex3;
    logic [6:0]  o_io_hex4;
    logic [6:0]  o_io_hex5;
    logic [6:0]  o_io_hex6;
    logic [6:0]  o_io_hex7;

    modport master (
        output i_wr_en, i_wr_data, i_mode,
        input  o_busy, o_done,
        input  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3,
        input  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_mode,
        output o_busy, o_done,
        output o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3,
        output o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl
// Purpose : drives eight 7-segment digits from one 32-bit write, shown either
//           in hexadecimal or in unsigned decimal. Decimal uses a multi-cycle
//           shift-add-3 (double-dabble) engine; o_busy/o_done tell the store
//           path when another write may be issued.
// Ports   :
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-high reset
//   io_bus   seg_display_ctrl_if.slave (write strobe/data/mode in,
//            busy/done handshake and o_io_hex0..7 segment pins out)
// Parameters:
//   CONV_BITS  number of input bits run through the decimal engine
//   OVF_SEG    pattern shown on every digit when the decimal value > 99999999
// Optional feature macro:
//   SEG_LZ_BLANK_EN  when defined, leading zero digits (hex7 downward) are
//                    blanked; hex0 is always shown. Overflow is unaffected.
// ---------------------------------------------------------------------------
module seg_display_ctrl #(
    parameter int          CONV_BITS = 32,
    parameter logic [6:0]  OVF_SEG   = 7'h3F
) (
    input  logic                i_clk,
    input  logic                i_reset,
    seg_display_ctrl_if.slave   io_bus
);

    localparam int CNT_W = $clog2(CONV_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_shift;
    logic [39:0]      r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_busy;
    logic             r_done;
    logic [6:0]       r_hex [8];

    logic [39:0]      w_bcdAdj;
    logic [3:0]       w_nib [8];
    logic [6:0]       w_seg [8];
    logic             w_ovf;

    // Active-low nibble to segment decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Add-3 correction applied to every BCD digit that is 5 or more, done
    // before the shift so the digit carries correctly into the next decade.
    always_comb begin
        w_bcdAdj = r_bcd;
        for (int k = 0; k < 10; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcdAdj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Digit selection and decode feeding the output registers. In hex mode
    // the shift register never moves, so it still holds the written value.
    // The leading-zero blanker walks from hex7 down and stops at the first
    // nonzero digit; hex0 is excluded so a zero value still shows "0".
    always_comb begin
        logic leading;
        leading = 1'b1;
        w_ovf   = r_mode && (r_bcd[39:32] != 8'h0);
        for (int k = 0; k < 8; k++) begin
            w_nib[k] = r_mode ? r_bcd[4*k +: 4] : r_shift[4*k +: 4];
            w_seg[k] = w_ovf ? OVF_SEG : segDecode(w_nib[k]);
        end
`ifdef SEG_LZ_BLANK_EN
        for (int k = 7; k > 0; k--) begin
            if (!w_ovf && leading && (w_nib[k] == 4'h0)) begin
                w_seg[k] = 7'h7F;
            end else begin
                leading = 1'b0;
            end
        end
`else
        leading = 1'b0;
`endif
    end

    // Controller FSM. Busy and done are registered alongside the state so
    // o_busy tracks "state != IDLE" exactly and o_done lands in the cycle the
    // new digits appear. Writes outside IDLE are simply not looked at.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                r_hex[k] <= 7'h7F;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (io_bus.i_wr_en) begin
                        r_shift <= io_bus.i_wr_data;
                        r_mode  <= io_bus.i_mode;
                        r_busy  <= 1'b1;
                        if (io_bus.i_mode) begin
                            r_bcd   <= '0;
                            r_cnt   <= '0;
                            r_state <= CONV;
                        end else begin
                            r_state <= UPDATE;
                        end
                    end
                end
                CONV: begin
                    r_bcd   <= {w_bcdAdj[38:0], r_shift[31]};
                    r_shift <= {r_shift[30:0], 1'b0};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(CONV_BITS - 1)) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    for (int k = 0; k < 8; k++) begin
                        r_hex[k] <= w_seg[k];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.o_busy    = r_busy;
    assign io_bus.o_done    = r_done;
    assign io_bus.o_io_hex0 = r_hex[0];
    assign io_bus.o_io_hex1 = r_hex[1];
    assign io_bus.o_io_hex2 = r_hex[2];
    assign io_bus.o_io_hex3 = r_hex[3];
    assign io_bus.o_io_hex4 = r_hex[4];
    assign io_bus.o_io_hex5 = r_hex[5];
    assign io_bus.o_io_hex6 = r_hex[6];
    assign io_bus.o_io_hex7 = r_hex[7];

endmodule
